// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit holding the MIPS HI/LO registers.
// The result is computed at accept time and held pending until the busy window ends.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]  phi_q, phi_d, plo_q, plo_d;

  // Datapath: every result form is computed combinationally from A/B.
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe_s, b_safe_u;
  logic [WIDTH-1:0]   uq_s, ur_s, q_s, r_s, q_u, r_u;

  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  assign a_neg  = A[WIDTH-1];
  assign b_neg  = B[WIDTH-1];
  assign b_zero = (B == '0);
  assign a_mag  = a_neg ? ({WIDTH{1'b0}} - A) : A;
  assign b_mag  = b_neg ? ({WIDTH{1'b0}} - B) : B;

  // Substitute divisor 1 on zero so the dividers never see /0; the result is overridden below.
  assign b_safe_s = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign b_safe_u = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : B;

  // Magnitude divide then sign-fix: truncation toward zero, remainder follows dividend.
  // Most-negative / -1 falls out naturally as quotient = A, remainder = 0.
  assign uq_s = a_mag / b_safe_s;
  assign ur_s = a_mag % b_safe_s;
  assign q_s  = b_zero ? {WIDTH{1'b1}} : ((a_neg ^ b_neg) ? ({WIDTH{1'b0}} - uq_s) : uq_s);
  assign r_s  = b_zero ? A             : (a_neg ? ({WIDTH{1'b0}} - ur_s) : ur_s);
  assign q_u  = b_zero ? {WIDTH{1'b1}} : (A / b_safe_u);
  assign r_u  = b_zero ? A             : (A % b_safe_u);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT:  begin {phi_d, plo_d} = prod_s;   cnt_d = MULT_CNT; state_d = RUN; end
            OP_MULTU: begin {phi_d, plo_d} = prod_u;   cnt_d = MULT_CNT; state_d = RUN; end
            OP_DIV:   begin phi_d = r_s; plo_d = q_s;  cnt_d = DIV_CNT;  state_d = RUN; end
            OP_DIVU:  begin phi_d = r_u; plo_d = q_u;  cnt_d = DIV_CNT;  state_d = RUN; end
            OP_MTHI:  hi_d = A;
            OP_MTLO:  lo_d = A;
            default:  ;
          endcase
        end
      end
      RUN: begin
        // start is ignored here; the pipeline never issues while busy.
        if (cnt_q == CNT_ONE) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      // NOTE: pending registers are cleared too so a reset mid-RUN leaves no stale result.
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic reference model checked every cycle,
// plus literal expectations for the documented vectors.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain signed/unsigned arithmetic, busy as cycles remaining.
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
        OP_MULT: begin
          p = 64'(sa * sb);
          m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
        end
        OP_MULTU: begin
          p = {32'b0, a} * {32'b0, b};
          m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
        end
        OP_DIV: begin
          if (b == 0) begin
            m_plo = '1; m_phi = a;
          end else begin
            sq = sa / sb; sr = sa % sb;
            m_plo = sq[31:0]; m_phi = sr[31:0];
          end
          m_left = 10;
        end
        OP_DIVU: begin
          if (b == 0) begin
            m_plo = '1; m_phi = a;
          end else begin
            m_plo = a / b; m_phi = a % b;
          end
          m_left = 10;
        end
        OP_MTHI: m_hi = a;
        OP_MTLO: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'b0, busy}, {31'b0, (m_left > 0)});
      check("model_hi", hi, m_hi);
      check("model_lo", lo, m_lo);
    end
  end

  // Called at a negedge; holds start for exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
  endtask

  // Counts busy cycles after an accept; bounded so a stuck busy shows as a wrong length.
  task automatic busy_len(input string name, input int exp_len);
    int n = 0;
    while (busy && n < 64) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_len));
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    busy_len("mult_busy_len", 5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    busy_len("multu_busy_len", 5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len("div_busy_len", 10);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    busy_len("div2_busy_len", 10);
    check("div_negb_lo", lo, 32'hFFFF_FFFD);
    check("div_negb_hi", hi, 32'h0000_0001);

    issue(OP_DIVU, 32'd5, 32'd0);
    busy_len("divu0_busy_len", 10);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0005);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len("ovf_busy_len", 10);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);

    issue(OP_DIV, 32'hFFFF_FFF7, 32'd0);
    busy_len("div0_busy_len", 10);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF7);

    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    check("mthi_hi", hi, 32'h0000_1234);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    check("mthi_lo", lo, 32'hFFFF_FFFF);

    issue(OP_MTLO, 32'h0000_5678, 32'd0);
    check("mtlo_lo", lo, 32'h0000_5678);
    check("mtlo_hi", hi, 32'h0000_1234);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    check("nop_busy", {31'b0, busy}, 32'd0);
    check("nop_hi", hi, 32'h0000_1234);
    check("nop_lo", lo, 32'h0000_5678);

    // Second start during the busy window must be ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    issue(OP_MULT, 32'd3, 32'd3);
    busy_len("ignored_busy_len", 8);
    check("ignored_lo", lo, 32'd14);
    check("ignored_hi", hi, 32'd2);
    @(negedge clk);
    check("ignored_idle", {31'b0, busy}, 32'd0);

    // Reset mid-RUN discards the pending result.
    issue(OP_DIVU, 32'd50, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstrun_busy", {31'b0, busy}, 32'd0);
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("rstrun_late_hi", hi, 32'd0);
    check("rstrun_late_lo", lo, 32'd0);
    check("rstrun_late_busy", {31'b0, busy}, 32'd0);

    // Back-to-back issue at the first idle edge.
    issue(OP_MULTU, 32'd6, 32'd7);
    busy_len("b2b1_busy_len", 5);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busy_len("b2b2_busy_len", 5);
    check("b2b_lo", lo, 32'd1);
    check("b2b_hi", hi, 32'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes MULT/MULTU/DIV/DIVU over a configurable number of cycles and performs MTHI/MTLO writes. It holds the HI/LO registers and raises `busy` so the hazard logic can stall later MDU instructions in D.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy duration for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, 10: busy duration for DIV/DIVU; must be ≥1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `start`  in  1  qualifies `op` this cycle.
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
- `A`  in  WIDTH  rs value (forwarded).
- `B`  in  WIDTH  rt value (forwarded).
- `busy`  out  1  a multi-cycle operation is in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- State machine: IDLE and RUN. A down-counter wide enough for max(MULT_CYCLES, DIV_CYCLES) runs in RUN. `busy` = (state == RUN).
- Accept condition: `start` is high and state is IDLE at the edge.
- On accepting ops 0–3:
  - Compute the result from `A`/`B` at that edge and latch it into pending registers. Operands may change afterwards.
  - Load the counter with the op's cycle count and go to RUN.
- MULT: signed 2·WIDTH product. MULTU: unsigned product. In both, {HI, LO} = product.
- DIV/DIVU: LO = quotient and HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Example: −7/2 gives LO = −3, HI = −1.
- Divide by zero, signed or unsigned: LO = all ones, HI = A.
- Signed overflow (A = most-negative, B = −1): LO = A, HI = 0.
- MTHI/MTLO accepted in IDLE: HI (or LO) = A at that edge. `busy` stays 0. The other register is unchanged.
- In RUN: the counter decrements each edge. At the edge where it would reach 0, HI/LO load the pending result and state returns to IDLE.
- `start` while in RUN is ignored: no state, counter, or HI/LO change. The pipeline stalls any MDU instruction in E while `busy`, so this never occurs legally.
- Ops 6 and 7 with `start` do nothing.
- `reset`: state IDLE, counter 0, HI = 0, LO = 0, `busy` = 0. It overrides `start` in the same cycle.
- Reset mid-RUN discards the pending result.

## Timing
- Accept of a mult/div at edge k:
  - `busy` = 1 from after edge k through edge k+N, where N is the op's cycle count.
  - HI/LO update at edge k+N. `busy` = 0 after edge k+N.
- During busy, HI/LO hold their old values. An MFHI/MFLO issued during busy is stalled upstream, not here.
- A new op may be accepted at the first edge with `busy` = 0. Back-to-back issue has a period of N+1 cycles.
- MTHI/MTLO: latency 1. The value is visible on HI/LO after the accepting edge.
- Reset values of all outputs: `busy` 0, HI 0, LO 0.

## Test plan
- Reset, then MULT, A=0xFFFFFFFE (−2), B=3 at edge k -> `busy` high for 5 cycles; at k+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA, `busy` falls.
- MULTU, A=0xFFFFFFFF, B=2 -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=−7, B=2, with A/B changed to 0 the next cycle -> after 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=5, B=0 -> LO=0xFFFFFFFF, HI=5. DIV, A=0x80000000, B=−1 -> LO=0x80000000, HI=0.
- MTHI, A=0x1234 -> HI=0x1234 next cycle, `busy` stays 0, LO unchanged. A second `start` (MULT) during a DIV's busy window is ignored and the DIV result is intact.
- DIV accepted, `reset` asserted 4 cycles later -> `busy`=0, HI=LO=0 the next cycle, and no later update occurs.
